sipo_rx: RTL and testbench

//  Serial-in parallel-out receiver: the far end of the piso shift-register link.

---
 rtl/sipo_rx.sv | 86 ++++++++
 tb/tb_sipo_rx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver: assembles WIDTH-bit words from a gated serial
// stream and holds each one in an output register with a valid/ack handshake.
module sipo_rx #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     sin,
    input  logic                     sel,
    input  logic                     d_ack,
    output logic [WIDTH-1:0]         d_out,
    output logic                     d_valid,
    output logic                     busy,
    output logic [$clog2(WIDTH)-1:0] bit_cnt,
    output logic                     overrun
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;
    logic             complete;

    always_comb begin
        shifted = shreg;
        if (MSB_FIRST) begin
            shifted = {shreg[WIDTH-2:0], sin};
        end else begin
            shifted = {sin, shreg[WIDTH-1:1]};
        end
        // The edge sampling the last bit completes the word, including that bit.
        complete = sel && (state == StShift) && (bit_cnt == LastCnt);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= StIdle;
            shreg   <= '0;
            bit_cnt <= '0;
            d_out   <= '0;
            d_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (sel) begin
                shreg <= shifted;
                unique case (state)
                    StIdle: begin
                        state   <= StShift;
                        bit_cnt <= CW'(1);
                    end
                    StShift: begin
                        if (bit_cnt == LastCnt) begin
                            state   <= StIdle;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state   <= StIdle;
                        bit_cnt <= '0;
                    end
                endcase
            end

            if (complete) begin
                if (!d_valid || d_ack) begin
                    d_out   <= shifted;
                    d_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (d_ack) begin
                d_valid <= 1'b0;
            end
        end
    end

    assign busy = (state == StShift);

endmodule

// File: tb/tb_sipo_rx.sv
// Scoreboarded bench for sipo_rx: one MSB-first and one LSB-first instance, each
// with its own expected-word queue drained by a monitor on every acked valid word.
module tb_sipo_rx;

    logic       clk = 1'b0;
    logic       clr, sin, sel, d_ack;
    logic [3:0] d_out;
    logic       d_valid, busy, overrun;
    logic [1:0] bit_cnt;

    logic       clr2, sin2, sel2, d_ack2;
    logic [3:0] d_out2;
    logic       d_valid2, busy2, overrun2;
    logic [1:0] bit_cnt2;

    int total = 0;
    int bad   = 0;

    logic [3:0] exp_q[$];
    logic [3:0] exp_q2[$];

    always #5 clk = ~clk;

    sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .clr(clr), .sin(sin), .sel(sel), .d_ack(d_ack),
        .d_out(d_out), .d_valid(d_valid), .busy(busy), .bit_cnt(bit_cnt),
        .overrun(overrun)
    );

    sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut2 (
        .clk(clk), .clr(clr2), .sin(sin2), .sel(sel2), .d_ack(d_ack2),
        .d_out(d_out2), .d_valid(d_valid2), .busy(busy2), .bit_cnt(bit_cnt2),
        .overrun(overrun2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read at that point too.
    task automatic cyc(input logic c, input logic s, input logic b, input logic a);
        clr = c; sel = s; sin = b; d_ack = a;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc2(input logic c, input logic s, input logic b, input logic a);
        clr2 = c; sel2 = s; sin2 = b; d_ack2 = a;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] w, input logic ack_last);
        for (int i = 3; i >= 0; i--) cyc(1'b0, 1'b1, w[i], (i == 0) ? ack_last : 1'b0);
    endtask

    always @(negedge clk) begin
        if (!clr && d_valid && d_ack) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL word_a: got=%b want=none", d_out);
            end else begin
                logic [3:0] w;
                w = exp_q.pop_front();
                if (d_out !== w) begin
                    bad++;
                    $display("FAIL word_a: got=%b want=%b at %0t", d_out, w, $time);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!clr2 && d_valid2 && d_ack2) begin
            total++;
            if (exp_q2.size() == 0) begin
                bad++;
                $display("FAIL word_b: got=%b want=none", d_out2);
            end else begin
                logic [3:0] w;
                w = exp_q2.pop_front();
                if (d_out2 !== w) begin
                    bad++;
                    $display("FAIL word_b: got=%b want=%b at %0t", d_out2, w, $time);
                end
            end
        end
    end

    initial begin
        clr2 = 1'b1; sel2 = 1'b0; sin2 = 1'b0; d_ack2 = 1'b0;

        // Reset
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        check("rst_dout", d_out, 4'h0);
        check("rst_valid", d_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_cnt", bit_cnt, 0);
        check("rst_ovr", overrun, 0);

        // Basic word and ack
        exp_q.push_back(4'b0100);
        cyc(0, 1, 0, 0);
        check("cnt_first", bit_cnt, 1);
        check("busy_first", busy, 1);
        cyc(0, 1, 1, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        check("w1_dout", d_out, 4'b0100);
        check("w1_valid", d_valid, 1);
        check("w1_busy", busy, 0);
        check("w1_cnt", bit_cnt, 0);
        cyc(0, 0, 0, 1);
        check("ack_valid", d_valid, 0);
        check("ack_dout", d_out, 4'b0100);

        // Pause mid-word; sin toggles while sel=0 must be ignored
        cyc(0, 1, 1, 0);
        cyc(0, 1, 1, 0);
        check("pause_cnt0", bit_cnt, 2);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, i[0], 0);
            check("pause_cnt", bit_cnt, 2);
            check("pause_busy", busy, 1);
        end
        exp_q.push_back(4'b1110);
        cyc(0, 1, 1, 0);
        cyc(0, 1, 0, 0);
        check("w2_dout", d_out, 4'b1110);
        check("w2_valid", d_valid, 1);
        cyc(0, 0, 0, 1);

        // Overrun: second word dropped while first is unacked
        send(4'b0100, 0);
        send(4'b1110, 0);
        check("ovr_dout", d_out, 4'b0100);
        check("ovr_flag", overrun, 1);
        check("ovr_valid", d_valid, 1);
        exp_q.push_back(4'b0100);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        check("ovr_sticky", overrun, 1);
        check("ovr_cnt", bit_cnt, 0);

        // Ack on the completing edge lets the new word in without overrun
        cyc(1, 0, 0, 0);
        check("clr_ovr", overrun, 0);
        send(4'b0100, 0);
        exp_q.push_back(4'b0100);
        send(4'b1110, 1);
        check("ackc_dout", d_out, 4'b1110);
        check("ackc_valid", d_valid, 1);
        check("ackc_ovr", overrun, 0);
        exp_q.push_back(4'b1110);
        cyc(0, 0, 0, 1);

        // clr discards a partial word
        cyc(0, 1, 1, 0);
        cyc(0, 1, 1, 0);
        cyc(1, 0, 0, 0);
        check("clr_cnt", bit_cnt, 0);
        check("clr_busy", busy, 0);
        exp_q.push_back(4'b1010);
        send(4'b1010, 0);
        check("w5_dout", d_out, 4'b1010);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);

        // LSB-first instance, then continuous streaming with d_ack held
        cyc2(1, 0, 0, 0);
        exp_q2.push_back(4'b0100);
        cyc2(0, 1, 0, 0);
        cyc2(0, 1, 0, 0);
        cyc2(0, 1, 1, 0);
        cyc2(0, 1, 0, 0);
        check("lsb_dout", d_out2, 4'b0100);
        check("lsb_valid", d_valid2, 1);
        exp_q2.push_back(4'b0001);
        exp_q2.push_back(4'b1011);
        begin
            logic [7:0] bits;
            bits = 8'b1011_0001;
            for (int i = 0; i < 8; i++) cyc2(0, 1, bits[i], 1);
        end
        check("strm_dout", d_out2, 4'b1011);
        check("strm_valid", d_valid2, 1);
        check("strm_ovr", overrun2, 0);
        cyc2(0, 0, 0, 1);
        cyc2(0, 0, 0, 0);

        check("q_a_empty", exp_q.size(), 0);
        check("q_b_empty", exp_q2.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
